// File: rtl/nes_clk_pkg.sv
// Shared definitions for the NES clock-enable generator.
//   clk_state_e      : sequencer states
//   NES_NTSC_CPU_DIV : master clocks per CPU cycle (NTSC)
//   NES_NTSC_PPU_DIV : master clocks per PPU dot (NTSC)
//   CPU_CYCLES_W     : width of the debug CPU cycle counter
package nes_clk_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    PAUSED,
    STEP
  } clk_state_e;

  localparam int NES_NTSC_CPU_DIV = 12;
  localparam int NES_NTSC_PPU_DIV = 4;
  localparam int CPU_CYCLES_W     = 32;

endpackage

// File: rtl/nes_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level, reset value 0.
//   clk : destination clock
//   rst : synchronous active-high clear of both stages
//   d   : asynchronous input
//   q   : synchronized output
module nes_sync_bit
  import nes_clk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_clk_enable_gen.sv
// NES core reset sequencer and clock-enable generator. Holds the core in
// reset until the PLL lock has been stable, then issues aligned one-clk
// PPU/CPU/APU enables, with pause / single-step control.
//   clk        : PLL output clock
//   rst        : synchronous active-high reset
//   pll_locked : PLL lock (asynchronous, synchronized here)
//   pause      : level, halt at the next CPU cycle boundary
//   step       : pulse, run one CPU cycle while paused
//   sys_rst    : core reset
//   ppu_ce     : PPU dot enable
//   cpu_ce     : CPU cycle enable
//   apu_ce     : APU enable, every second cpu_ce
//   running    : high in RUN and during a step
//   cpu_cycles : cpu_ce count since last sys_rst release
// Build option: define NES_CLK_STEP_EN to implement single-step.
//
// state     | meaning
// HOLD      | minimum reset hold after rst, lock synchronizer held clear
// WAIT_LOCK | core in reset, waiting for lock
// STABLE    | core in reset, counting consecutive locked cycles
// RUN       | core running, enables generated
// PAUSED    | core halted at a CPU cycle boundary, counters frozen
// STEP      | one CPU cycle of RUN, then back to PAUSED
module nes_clk_enable_gen
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV            = NES_NTSC_CPU_DIV,
  parameter int PPU_DIV            = NES_NTSC_PPU_DIV,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    pause,
  input  logic                    step,
  output logic                    sys_rst,
  output logic                    ppu_ce,
  output logic                    cpu_ce,
  output logic                    apu_ce,
  output logic                    running,
  output logic [CPU_CYCLES_W-1:0] cpu_cycles
);

  localparam int PH_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int SUB_W  = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CPU_DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PPU_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);

  clk_state_e              state;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [STAB_W-1:0]       stab_cnt;
  logic [PH_W-1:0]         phase;
  logic [SUB_W-1:0]        sub;
  logic                    apu_tog;
  logic [CPU_CYCLES_W-1:0] cycle_cnt;
  logic                    locked;
  logic                    sync_rst;
  logic                    active;
  logic                    tick_cpu;
  logic                    lock_lost;

`ifdef NES_CLK_STEP_EN
  logic step_req;
  assign step_req = step;
`else
  logic step_unused;
  assign step_unused = step;
`endif

  // Clearing the synchronizer during HOLD makes lock qualification always
  // start from freshly sampled lock, never from a value captured before rst.
  assign sync_rst = rst || (state == HOLD);

  nes_sync_bit u_lock_sync (
    .clk (clk),
    .rst (sync_rst),
    .d   (pll_locked),
    .q   (locked)
  );

  assign active     = (state == RUN) || (state == STEP);
  assign tick_cpu   = active && (phase == PH_LAST);
  assign lock_lost  = !locked && (active || (state == PAUSED));
  assign cpu_cycles = cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= HOLD_INIT;
      stab_cnt  <= '0;
      phase     <= '0;
      sub       <= '0;
      apu_tog   <= 1'b0;
      cycle_cnt <= '0;
      sys_rst   <= 1'b1;
      ppu_ce    <= 1'b0;
      cpu_ce    <= 1'b0;
      apu_ce    <= 1'b0;
      running   <= 1'b0;
    end else begin
      ppu_ce <= 1'b0;
      cpu_ce <= 1'b0;
      apu_ce <= 1'b0;
      if (lock_lost) begin
        state     <= WAIT_LOCK;
        sys_rst   <= 1'b1;
        running   <= 1'b0;
        phase     <= '0;
        sub       <= '0;
        apu_tog   <= 1'b0;
        cycle_cnt <= '0;
      end else begin
        // Enables are registered from the pre-advance counter values, so the
        // first pulse lands PPU_DIV / CPU_DIV clocks after entering RUN.
        if (active) begin
          sub    <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
          phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
          ppu_ce <= (sub == SUB_LAST);
          cpu_ce <= (phase == PH_LAST);
          if (phase == PH_LAST) begin
            apu_ce    <= apu_tog;
            apu_tog   <= ~apu_tog;
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        case (state)
          HOLD: begin
            if (hold_cnt == '0) state <= WAIT_LOCK;
            else                hold_cnt <= hold_cnt - 1'b1;
          end
          WAIT_LOCK: begin
            stab_cnt <= '0;
            if (locked) state <= STABLE;
          end
          STABLE: begin
            if (!locked) begin
              state <= WAIT_LOCK;
            end else if (stab_cnt == STAB_LAST) begin
              state   <= RUN;
              sys_rst <= 1'b0;
              running <= 1'b1;
            end else begin
              stab_cnt <= stab_cnt + 1'b1;
            end
          end
          RUN: begin
            if (tick_cpu && pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            if (!pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
`ifdef NES_CLK_STEP_EN
            else if (step_req) begin
              state   <= STEP;
              running <= 1'b1;
            end
`endif
          end
`ifdef NES_CLK_STEP_EN
          STEP: begin
            if (tick_cpu) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
`endif
          default: begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
            sys_rst  <= 1'b1;
            running  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_clk_enable_gen.sv
`timescale 1ns/1ps
module tb_nes_clk_enable_gen;

  localparam int CPU_DIV = 12;
  localparam int PPU_DIV = 4;
  localparam int LOCK_N  = 8;
  localparam int HOLD_N  = 16;
`ifdef NES_CLK_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pll_locked, pause, step;
  logic        sys_rst, ppu_ce, cpu_ce, apu_ce, running;
  logic [31:0] cpu_cycles;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nes_clk_enable_gen #(
    .CPU_DIV(CPU_DIV), .PPU_DIV(PPU_DIV),
    .LOCK_STABLE_CYCLES(LOCK_N), .RESET_HOLD_CYCLES(HOLD_N)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pause(pause), .step(step),
    .sys_rst(sys_rst), .ppu_ce(ppu_ce), .cpu_ce(cpu_ce), .apu_ce(apu_ce),
    .running(running), .cpu_cycles(cpu_cycles)
  );

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model. Lock is seen two clocks late (never during the
  // post-rst hold); the core is released after LOCK_N+1 consecutive locked
  // clocks; enables follow from the number of active clocks since release.
  int          m_n, m_qual, m_act, m_step_left;
  bit          m_p1, m_p2, m_rel, m_halt, m_ppu, m_cpu, m_apu;
  logic [31:0] m_cycles;

  always @(posedge clk) begin : model
    bit lk;
    lk = m_p2;
    m_ppu = 1'b0; m_cpu = 1'b0; m_apu = 1'b0;
    if (rst) begin
      m_n = 0; m_p1 = 0; m_p2 = 0; m_qual = 0; m_rel = 0; m_halt = 0;
      m_step_left = 0; m_act = 0; m_cycles = 0;
    end else begin
      if (m_n < 1000) m_n++;
      if (m_n <= HOLD_N) begin m_p1 = 0; m_p2 = 0; end
      else begin m_p2 = m_p1; m_p1 = pll_locked; end
      if (!m_rel) begin
        if (lk) m_qual++; else m_qual = 0;
        if (m_qual == LOCK_N + 1) begin
          m_rel = 1; m_qual = 0; m_act = 0; m_halt = 0; m_step_left = 0;
        end
      end else if (!lk) begin
        m_rel = 0; m_qual = 0; m_act = 0; m_halt = 0; m_step_left = 0; m_cycles = 0;
      end else if (m_halt && m_step_left == 0) begin
        if (!pause) m_halt = 0;
        else if (STEP_ON && step) m_step_left = CPU_DIV;
      end else begin
        m_act++;
        if (m_step_left > 0) m_step_left--;
        m_ppu = (m_act % PPU_DIV == 0);
        m_cpu = (m_act % CPU_DIV == 0);
        if (m_cpu) begin
          m_cycles = m_cycles + 1;
          m_apu = ((m_act / CPU_DIV) % 2 == 0);
          if (pause) m_halt = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk_bit("cyc_sys_rst", sys_rst, !m_rel);
      chk_bit("cyc_ppu_ce", ppu_ce, m_ppu);
      chk_bit("cyc_cpu_ce", cpu_ce, m_cpu);
      chk_bit("cyc_apu_ce", apu_ce, m_apu);
      chk_bit("cyc_running", running, m_rel && (!m_halt || m_step_left > 0));
      chk_val("cyc_cpu_cycles", cpu_cycles, m_cycles);
    end
  end

  task automatic run_count(input int clks, output int np, output int nc, output int na, output int fc);
    np = 0; nc = 0; na = 0; fc = 0;
    for (int i = 1; i <= clks; i++) begin
      @(negedge clk);
      if (ppu_ce) np++;
      if (apu_ce) na++;
      if (cpu_ce) begin
        nc++;
        if (fc == 0) fc = i;
      end
    end
  endtask

  task automatic wait_rst_level(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sys_rst !== lvl && n < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, np, nc, na, fc;
    bit found;
    rst = 1'b1; pll_locked = 1'b1; pause = 1'b0; step = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk_bit("rst_sys_rst", sys_rst, 1'b1);
    chk_bit("rst_running", running, 1'b0);
    chk_bit("rst_cpu_ce", cpu_ce, 1'b0);
    chk_val("rst_cpu_cycles", cpu_cycles, 0);

    rst = 1'b0;
    wait_rst_level(1'b0, 200, n);
    chk_val("release_latency", n, HOLD_N + 2 + LOCK_N + 1);

    run_count(240, np, nc, na, fc);
    chk_val("run_ppu_count", np, 60);
    chk_val("run_cpu_count", nc, 20);
    chk_val("run_apu_count", na, 10);
    chk_val("first_cpu_ce", fc, 12);
    chk_val("run_cpu_cycles", cpu_cycles, 20);

    run_count(5, np, nc, na, fc);
    pause = 1'b1;
    run_count(30, np, nc, na, fc);
    chk_val("pause_ppu_count", np, 2);
    chk_val("pause_cpu_count", nc, 1);
    chk_val("pause_apu_count", na, 0);
    chk_val("pause_cpu_at", fc, 7);
    chk_bit("pause_running", running, 1'b0);
    chk_val("pause_cpu_cycles", cpu_cycles, 21);

    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    run_count(20, np, nc, na, fc);
    chk_val("step_ppu_count", np, STEP_ON ? 3 : 0);
    chk_val("step_cpu_count", nc, STEP_ON ? 1 : 0);
    chk_val("step_apu_count", na, STEP_ON ? 1 : 0);
    chk_bit("step_running", running, 1'b0);
    chk_val("step_cpu_cycles", cpu_cycles, STEP_ON ? 22 : 21);

    pause = 1'b0;
    run_count(48, np, nc, na, fc);
    chk_val("resume_cpu_count", nc, 3);

    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_rst_level(1'b1, 20, n);
    chk_val("lock_loss_latency", n + 1, 3);
    chk_val("lock_loss_cpu_cycles", cpu_cycles, 0);
    chk_bit("lock_loss_enables", ppu_ce | cpu_ce | apu_ce, 1'b0);
    wait_rst_level(1'b0, 200, n);
    chk_val("requal_latency", n, LOCK_N + 1);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (m_act % CPU_DIV == 1) found = 1'b1;
    end
    chk_bit("wrap_align_found", found, 1'b1);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    m_cycles = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.cycle_cnt;
    repeat (CPU_DIV - 2) @(posedge clk);
    @(negedge clk);
    chk_bit("wrap_cpu_ce", cpu_ce, 1'b1);
    chk_val("wrap_cpu_cycles", cpu_cycles, 0);

    run_count(7, np, nc, na, fc);
    rst = 1'b1;
    @(negedge clk);
    chk_bit("midrst_sys_rst", sys_rst, 1'b1);
    chk_bit("midrst_running", running, 1'b0);
    chk_val("midrst_cpu_cycles", cpu_cycles, 0);
    rst = 1'b0;
    wait_rst_level(1'b0, 200, n);
    chk_val("rerelease_latency", n, HOLD_N + 2 + LOCK_N + 1);
    run_count(24, np, nc, na, fc);
    chk_val("final_cpu_count", nc, 2);
    chk_val("final_apu_count", na, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
